multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle simple_cpu. It sequences fetch, decode, execute, memory and write-back across the existing decode/datapath. It owns the valid/ready handshakes with instruction and data memory, and gates the IR/PC/RF/memory write strobes. It also keeps cycle and retired-instruction performance counters.

Parameters:
CNT_W, 32, width of the cycle_cnt and inst_cnt performance counters

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
is_nop  input  1  decoded instruction is NOP (all-zero word)
is_load  input  1  decoded load class
is_store  input  1  decoded store class
is_branch  input  1  decoded conditional branch
is_jump  input  1  decoded J/JR class
writes_reg  input  1  instruction writes RF (R-type, I-type ALU, load, JAL/JALR)
branch_taken  input  1  branch condition true, valid in EX
Inst_Req_Valid  output  1  instruction request valid
Inst_Req_Ready  input  1  instruction memory accepts request
Inst_Valid  input  1  instruction word returned
Inst_Ready  output  1  controller ready for instruction word
MemRead  output  1  data read request (valid)
MemWrite  output  1  data write request (valid)
Mem_Req_Ready  input  1  data memory accepts request
Read_data_Valid  input  1  load data returned
Read_data_Ready  output  1  controller ready for load data
IR_we  output  1  latch instruction register
PC_we  output  1  update PC
PC_sel  output  1  0: PC+4, 1: branch/jump target
RegWrite  output  1  RF write enable
retire  output  1  one-cycle pulse per completed instruction
cycle_cnt  output  CNT_W  cycles since reset
inst_cnt  output  CNT_W  retired instructions since reset

Behaviour:
- States: INIT, IF, IW, ID, EX, ST, LD, RDW, WB. Encoding is one-hot. Outputs are decoded from the current state plus inputs; no output depends on the next state.
- Reset: state=INIT. All strobes/valid/ready outputs are 0. cycle_cnt=0, inst_cnt=0.
- Reset mid-operation: same as above on the next edge. Any pending request is dropped. No strobe is asserted in the cycle after rst.
- INIT -> IF unconditionally.
- IF:
  - Inst_Req_Valid=1.
  - If Inst_Req_Ready, go to IW; else hold with Inst_Req_Valid held high.
- IW:
  - Inst_Ready=1.
  - If Inst_Valid: IR_we=1, PC_we=1, PC_sel=0 (PC+4), go to ID.
  - Else hold.
- ID:
  - If is_nop: retire=1, go to IF.
  - Else go to EX.
- EX:
  - If (is_branch & branch_taken) or is_jump: PC_we=1, PC_sel=1.
  - Next state priority: is_load -> LD; is_store -> ST; writes_reg -> WB; else retire=1 and go to IF. This covers branches and J/JR without link.
- ST:
  - MemWrite=1.
  - If Mem_Req_Ready: retire=1, go to IF; else hold.
- LD:
  - MemRead=1.
  - If Mem_Req_Ready, go to RDW; else hold.
- RDW:
  - Read_data_Ready=1.
  - If Read_data_Valid, go to WB; else hold.
- WB: RegWrite=1, retire=1, go to IF.
- Handshakes:
  - A valid, once raised, stays high with stable request until ready is sampled high.
  - Transfer completes on the edge where valid&ready.
  - Ready may arrive in the same cycle valid rises; that gives a 1-cycle state.
- Latencies with zero-wait memory:
  - NOP: 3 cycles (IF, IW, ID).
  - Branch/J: 4 cycles.
  - ALU: 5 cycles.
  - Store: 5 cycles.
  - Load: 7 cycles.
- Counters:
  - cycle_cnt increments every cycle rst=0 and wraps modulo 2^CNT_W.
  - inst_cnt increments in each cycle retire=1 and wraps.
  - cycle_cnt is 0 in the first cycle after reset release and 1 the next.
- Illegal state (no one-hot bit set or multiple set): next state is INIT, and all strobes are 0 that cycle.
- Decode inputs are sampled only in ID/EX; their values elsewhere are don't-care.

Test Plan:
- Zero-wait ALU op (writes_reg=1, others 0) after reset -> states INIT,IF,IW,ID,EX,WB,IF; RegWrite high exactly 1 cycle; inst_cnt=1 after WB.
- Inst_Req_Ready held low 3 cycles in IF -> Inst_Req_Valid stays 1 for 4 cycles, IR_we not asserted, then IW entered.
- Load with Mem_Req_Ready delayed 2 cycles and Read_data_Valid delayed 1 -> MemRead high 3 cycles, Read_data_Ready high 2 cycles, RegWrite once, total 10 cycles.
- Branch with branch_taken=1 then branch_taken=0 -> first: PC_we with PC_sel=1 in EX, no RegWrite; second: no PC_we in EX; both retire in 4 cycles.
- NOP stream of 5 instructions, zero-wait -> inst_cnt=5 and cycle_cnt=16 (1 INIT + 15) at retire of the fifth.
- rst asserted while in LD with MemRead=1 -> next cycle MemRead=0, state INIT, counters 0; CNT_W=4 with 20 cycles -> cycle_cnt wraps to 4.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle simple_cpu: sequences IF/IW/ID/EX/ST/LD/RDW/WB,
// runs the instruction/data memory handshakes, gates write strobes and keeps perf counters.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_nop,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             writes_reg,
  input  logic             branch_taken,
  output logic             Inst_Req_Valid,
  input  logic             Inst_Req_Ready,
  input  logic             Inst_Valid,
  output logic             Inst_Ready,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic             Mem_Req_Ready,
  input  logic             Read_data_Valid,
  output logic             Read_data_Ready,
  output logic             IR_we,
  output logic             PC_we,
  output logic             PC_sel,
  output logic             RegWrite,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [8:0] {
    S_INIT = 9'b000000001,
    S_IF   = 9'b000000010,
    S_IW   = 9'b000000100,
    S_ID   = 9'b000001000,
    S_EX   = 9'b000010000,
    S_ST   = 9'b000100000,
    S_LD   = 9'b001000000,
    S_RDW  = 9'b010000000,
    S_WB   = 9'b100000000
  } state_t;

  state_t state, next_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      state     <= next_state;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    next_state      = state;
    Inst_Req_Valid  = 1'b0;
    Inst_Ready      = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    Read_data_Ready = 1'b0;
    IR_we           = 1'b0;
    PC_we           = 1'b0;
    PC_sel          = 1'b0;
    RegWrite        = 1'b0;
    retire          = 1'b0;

    case (state)
      S_INIT: next_state = S_IF;
      S_IF: begin
        Inst_Req_Valid = 1'b1;
        if (Inst_Req_Ready) next_state = S_IW;
      end
      S_IW: begin
        Inst_Ready = 1'b1;
        if (Inst_Valid) begin
          IR_we      = 1'b1;
          PC_we      = 1'b1;
          next_state = S_ID;
        end
      end
      S_ID: begin
        if (is_nop) begin
          retire     = 1'b1;
          next_state = S_IF;
        end else begin
          next_state = S_EX;
        end
      end
      S_EX: begin
        if ((is_branch && branch_taken) || is_jump) begin
          PC_we  = 1'b1;
          PC_sel = 1'b1;
        end
        // Memory classes take priority over a plain register write.
        if (is_load)         next_state = S_LD;
        else if (is_store)   next_state = S_ST;
        else if (writes_reg) next_state = S_WB;
        else begin
          retire     = 1'b1;
          next_state = S_IF;
        end
      end
      S_ST: begin
        MemWrite = 1'b1;
        if (Mem_Req_Ready) begin
          retire     = 1'b1;
          next_state = S_IF;
        end
      end
      S_LD: begin
        MemRead = 1'b1;
        if (Mem_Req_Ready) next_state = S_RDW;
      end
      S_RDW: begin
        Read_data_Ready = 1'b1;
        if (Read_data_Valid) next_state = S_WB;
      end
      S_WB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_IF;
      end
      // Zero or multiple one-hot bits: recover via INIT with all strobes low.
      default: next_state = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: zero-wait and stalled handshakes, every
// instruction class, counters, mid-operation reset and narrow-counter wrap.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic is_nop, is_load, is_store, is_branch, is_jump, writes_reg, branch_taken;
  logic Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid;
  logic Inst_Req_Valid, Inst_Ready, MemRead, MemWrite, Read_data_Ready;
  logic IR_we, PC_we, PC_sel, RegWrite, retire;
  logic [31:0] cycle_cnt, inst_cnt;

  logic n_irv, n_ir, n_mr, n_mw, n_rdr, n_irwe, n_pcwe, n_pcsel, n_rw, n_ret;
  logic [3:0] n_cycle_cnt, n_inst_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .is_nop(is_nop), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .writes_reg(writes_reg), .branch_taken(branch_taken),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .IR_we(IR_we), .PC_we(PC_we), .PC_sel(PC_sel), .RegWrite(RegWrite),
    .retire(retire), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  multicycle_ctrl #(.CNT_W(4)) u_narrow (
    .clk(clk), .rst(rst),
    .is_nop(is_nop), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .writes_reg(writes_reg), .branch_taken(branch_taken),
    .Inst_Req_Valid(n_irv), .Inst_Req_Ready(Inst_Req_Ready),
    .Inst_Valid(Inst_Valid), .Inst_Ready(n_ir),
    .MemRead(n_mr), .MemWrite(n_mw), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(n_rdr),
    .IR_we(n_irwe), .PC_we(n_pcwe), .PC_sel(n_pcsel), .RegWrite(n_rw),
    .retire(n_ret), .cycle_cnt(n_cycle_cnt), .inst_cnt(n_inst_cnt)
  );

  // {Inst_Req_Valid, Inst_Ready, MemRead, MemWrite, Read_data_Ready,
  //  IR_we, PC_we, PC_sel, RegWrite, retire}
  logic [9:0] strb;
  assign strb = {Inst_Req_Valid, Inst_Ready, MemRead, MemWrite, Read_data_Ready,
                 IR_we, PC_we, PC_sel, RegWrite, retire};

  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_IF   = 10'b1000000000;
  localparam logic [9:0] O_IW   = 10'b0100011000;
  localparam logic [9:0] O_LD   = 10'b0010000000;
  localparam logic [9:0] O_ST   = 10'b0001000001;
  localparam logic [9:0] O_RDW  = 10'b0000100000;
  localparam logic [9:0] O_WB   = 10'b0000000011;
  localparam logic [9:0] O_RET  = 10'b0000000001;
  localparam logic [9:0] O_JMP  = 10'b0000001101;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    {is_nop, is_load, is_store, is_branch, is_jump, writes_reg, branch_taken} = '0;
    {Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid} = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_strb", 32'(strb), 32'(O_NONE));
    check("rst_cyc", cycle_cnt, 0);
    check("rst_inst", inst_cnt, 0);

    // Zero-wait ALU instruction
    rst = 1'b0;
    {Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid} = '1;
    writes_reg = 1'b1;
    #1;
    check("alu_init", 32'(strb), 32'(O_NONE));
    check("alu_init_cyc", cycle_cnt, 0);
    tick(); check("alu_if", 32'(strb), 32'(O_IF));
    check("alu_if_cyc", cycle_cnt, 1);
    tick(); check("alu_iw", 32'(strb), 32'(O_IW));
    tick(); check("alu_id", 32'(strb), 32'(O_NONE));
    tick(); check("alu_ex", 32'(strb), 32'(O_NONE));
    tick(); check("alu_wb", 32'(strb), 32'(O_WB));
    check("alu_wb_inst", inst_cnt, 0);
    tick(); check("alu_next_if", 32'(strb), 32'(O_IF));
    check("alu_inst", inst_cnt, 1);
    check("alu_cyc", cycle_cnt, 6);

    // Inst_Req_Ready low for 3 cycles, then a zero-wait store
    Inst_Req_Ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("ifstall_hold", 32'(strb), 32'(O_IF));
      tick();
    end
    Inst_Req_Ready = 1'b1;
    #1;
    check("ifstall_4th", 32'(strb), 32'(O_IF));
    tick();
    writes_reg = 1'b0;
    is_store   = 1'b1;
    #1;
    check("st_iw", 32'(strb), 32'(O_IW));
    tick(); check("st_id", 32'(strb), 32'(O_NONE));
    tick(); check("st_ex", 32'(strb), 32'(O_NONE));
    tick(); check("st_mem", 32'(strb), 32'(O_ST));
    tick(); check("st_inst", inst_cnt, 2);
    check("st_cyc", cycle_cnt, 14);

    // Load: Mem_Req_Ready late by 2 cycles, Read_data_Valid late by 1
    is_store   = 1'b0;
    is_load    = 1'b1;
    writes_reg = 1'b1;
    #1;
    check("ld_if", 32'(strb), 32'(O_IF));
    tick(); check("ld_iw", 32'(strb), 32'(O_IW));
    tick(); check("ld_id", 32'(strb), 32'(O_NONE));
    tick(); check("ld_ex", 32'(strb), 32'(O_NONE));
    tick(); Mem_Req_Ready = 1'b0; #1;
    check("ld_req1", 32'(strb), 32'(O_LD));
    tick(); check("ld_req2", 32'(strb), 32'(O_LD));
    tick(); Mem_Req_Ready = 1'b1; #1;
    check("ld_req3", 32'(strb), 32'(O_LD));
    tick(); Read_data_Valid = 1'b0; #1;
    check("ld_rdw1", 32'(strb), 32'(O_RDW));
    tick(); Read_data_Valid = 1'b1; #1;
    check("ld_rdw2", 32'(strb), 32'(O_RDW));
    tick(); check("ld_wb", 32'(strb), 32'(O_WB));
    tick(); check("ld_next_if", 32'(strb), 32'(O_IF));
    check("ld_inst", inst_cnt, 3);
    check("ld_cyc", cycle_cnt, 24);

    // Branch taken, branch not taken, jump
    is_load      = 1'b0;
    writes_reg   = 1'b0;
    is_branch    = 1'b1;
    branch_taken = 1'b1;
    #1;
    tick(); check("bt_iw", 32'(strb), 32'(O_IW));
    tick(); check("bt_id", 32'(strb), 32'(O_NONE));
    tick(); check("bt_ex", 32'(strb), 32'(O_JMP));
    tick(); check("bt_inst", inst_cnt, 4);
    branch_taken = 1'b0;
    #1;
    tick(); tick(); tick();
    check("bn_ex", 32'(strb), 32'(O_RET));
    tick(); check("bn_inst", inst_cnt, 5);
    is_branch = 1'b0;
    is_jump   = 1'b1;
    #1;
    tick(); tick(); tick();
    check("j_ex", 32'(strb), 32'(O_JMP));
    tick(); check("j_inst", inst_cnt, 6);
    check("j_cyc", cycle_cnt, 36);

    // Fresh reset, then a stream of five zero-wait NOPs
    rst = 1'b1;
    tick();
    check("rst2_strb", 32'(strb), 32'(O_NONE));
    check("rst2_cyc", cycle_cnt, 0);
    check("rst2_inst", inst_cnt, 0);
    rst     = 1'b0;
    is_jump = 1'b0;
    is_nop  = 1'b1;
    #1;
    check("nop_init", 32'(strb), 32'(O_NONE));
    tick();
    for (int i = 0; i < 5; i++) begin
      check("nop_if", 32'(strb), 32'(O_IF));
      tick(); check("nop_iw", 32'(strb), 32'(O_IW));
      tick(); check("nop_id", 32'(strb), 32'(O_RET));
      tick();
    end
    check("nop_inst", inst_cnt, 5);
    check("nop_cyc", cycle_cnt, 16);

    // Reset while a load request is pending
    is_nop        = 1'b0;
    is_load       = 1'b1;
    writes_reg    = 1'b1;
    Mem_Req_Ready = 1'b0;
    #1;
    tick(); tick(); tick(); tick();
    check("rld_ld", 32'(strb), 32'(O_LD));
    rst = 1'b1;
    tick();
    check("rld_strb", 32'(strb), 32'(O_NONE));
    check("rld_cyc", cycle_cnt, 0);
    check("rld_inst", inst_cnt, 0);
    check("rld_ncyc", 32'(n_cycle_cnt), 0);

    // 20 cycles after release: narrow counter wraps to 4
    rst            = 1'b0;
    Inst_Req_Ready = 1'b0;
    #1;
    repeat (20) tick();
    check("wrap_ncyc", 32'(n_cycle_cnt), 4);
    check("wrap_cyc", cycle_cnt, 20);
    check("wrap_ninst", 32'(n_inst_cnt), 0);
    check("wrap_strb", 32'(strb), 32'(O_IF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
